// File: rtl/wm8731_i2c_responder_pkg.sv
// Shared constants and types for the WM8731 control-port responder:
// device address, register indices, power-on register values and FSM states.
package wm8731_pkg;

   localparam logic [6:0] WM8731_ADDR = 7'h1A;

   typedef enum logic [6:0] {
      R_LIN    = 7'd0,
      R_RIN    = 7'd1,
      R_LHP    = 7'd2,
      R_RHP    = 7'd3,
      R_APATH  = 7'd4,
      R_DPATH  = 7'd5,
      R_PWR    = 7'd6,
      R_IFACE  = 7'd7,
      R_SRATE  = 7'd8,
      R_ACTIVE = 7'd9,
      R_RESET  = 7'd15
   } reg_idx_e;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ACK_A, S_HI, S_ACK_H, S_LO, S_ACK_L, S_IGNORE
   } state_t;

   function automatic logic [8:0] reg_default(input logic [3:0] idx);
      logic [8:0] v;
      case (idx)
         4'd0, 4'd1: v = 9'h097;
         4'd2, 4'd3: v = 9'h079;
         4'd4:       v = 9'h00A;
         4'd5:       v = 9'h008;
         4'd6:       v = 9'h09F;
         4'd7:       v = 9'h00A;
         default:    v = 9'h000;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/wm8731_i2c_responder_if.sv
// I2C pin bundle between a bus master (initializer or bench) and the responder.
interface wm8731_i2c_responder_if;
   // Open-drain bus: i_sda is the resolved line level; o_sda_oe=1 pulls it low,
   // the responder never drives it high. No valid/ready: the master owns SCL timing.
   logic i_scl;
   logic i_sda;
   logic o_sda_oe;

   modport master (output i_scl, output i_sda, input o_sda_oe);
   modport slave  (input i_scl, input i_sda, output o_sda_oe);
endinterface

// File: rtl/wm8731_i2c_responder_i2c_bus_cond.sv
// SCL/SDA synchronizers with one history flop, producing SCL edge and
// START/STOP pulses in the i_clk domain. Shared with the bus monitor.
module i2c_bus_cond #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_hist;
   logic                   r_sda_hist;
   logic                   w_scl;
   logic                   w_sda;

   // Flops reset to the idle-bus level so reset release never fakes a START.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_hist <= 1'b1;
         r_sda_hist <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
         r_scl_hist <= w_scl;
         r_sda_hist <= w_sda;
      end
   end

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign o_sda      = w_sda;
   assign o_scl_rise = w_scl & ~r_scl_hist;
   assign o_scl_fall = ~w_scl & r_scl_hist;
   assign o_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
   assign o_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// WM8731 control-port responder: ACKs 3-byte writes to DEV_ADDR, commits
// 16-bit words into a 16x9 shadow register file and counts bad traffic.
module wm8731_i2c_responder
   import wm8731_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = WM8731_ADDR,
   parameter int         SYNC_STAGES = 2,
   parameter int         NUM_REGS    = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   wm8731_i2c_responder_if.slave        bus_if,
   output logic                         o_wr_valid,
   output logic [6:0]                   o_wr_addr,
   output logic [8:0]                   o_wr_data,
   output logic                         o_busy,
   output logic [7:0]                   o_nack_cnt,
   output logic [7:0]                   o_bad_cnt,
   input  logic [3:0]                   i_rd_addr,
   output logic [8:0]                   o_rd_data,
   output state_t                       o_state
);

   localparam logic [7:0] LP_NUM_REGS = 8'(NUM_REGS);

   logic        w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [15:0] w_word;

   state_t      r_state;
   logic [2:0]  r_bit_cnt;
   logic        r_byte_done;
   logic [7:0]  r_shift;
   logic [7:0]  r_hi;
   logic        r_sda_oe;
   logic        r_busy;
   logic        r_wr_valid;
   logic [6:0]  r_wr_addr;
   logic [8:0]  r_wr_data;
   logic [7:0]  r_nack_cnt;
   logic [7:0]  r_bad_cnt;
   logic [8:0]  r_shadow [16];

   i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_scl      (bus_if.i_scl),
      .i_sda      (bus_if.i_sda),
      .o_sda      (w_sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   assign w_word = {r_hi, r_shift};

   always_ff @(posedge i_clk) begin
      r_wr_valid <= 1'b0;
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= 3'd0;
         r_byte_done <= 1'b0;
         r_shift     <= 8'd0;
         r_hi        <= 8'd0;
         r_sda_oe    <= 1'b0;
         r_busy      <= 1'b0;
         r_wr_addr   <= 7'd0;
         r_wr_data   <= 9'd0;
         r_nack_cnt  <= 8'd0;
         r_bad_cnt   <= 8'd0;
         for (int i = 0; i < 16; i++) r_shadow[i] <= reg_default(4'(i));
      end else if (w_start) begin
         r_state     <= S_ADDR;
         r_busy      <= 1'b1;
         r_bit_cnt   <= 3'd0;
         r_byte_done <= 1'b0;
         r_sda_oe    <= 1'b0;
      end else if (w_stop) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_byte_done <= 1'b0;
         r_sda_oe    <= 1'b0;
      end else begin
         case (r_state)
            S_ADDR, S_HI, S_LO: begin
               if (w_scl_rise) begin
                  r_shift   <= {r_shift[6:0], w_sda};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
               end else if (w_scl_fall && r_byte_done) begin
                  // Byte boundary: the fall after bit 8 opens the ACK slot.
                  r_byte_done <= 1'b0;
                  if (r_state == S_ADDR) begin
                     if (r_shift == {DEV_ADDR, 1'b0}) begin
                        r_state  <= S_ACK_A;
                        r_sda_oe <= 1'b1;
                     end else begin
                        r_state <= S_IGNORE;
                        if (r_nack_cnt != 8'hFF) r_nack_cnt <= r_nack_cnt + 8'd1;
                     end
                  end else if (r_state == S_HI) begin
                     r_hi     <= r_shift;
                     r_state  <= S_ACK_H;
                     r_sda_oe <= 1'b1;
                  end else begin
                     r_state    <= S_ACK_L;
                     r_sda_oe   <= 1'b1;
                     r_wr_valid <= 1'b1;
                     r_wr_addr  <= w_word[15:9];
                     r_wr_data  <= w_word[8:0];
                     if (w_word[15:9] == R_RESET) begin
                        for (int i = 0; i < 16; i++) r_shadow[i] <= reg_default(4'(i));
                     end else if ({1'b0, w_word[15:9]} < LP_NUM_REGS) begin
                        r_shadow[w_word[12:9]] <= w_word[8:0];
                     end else if (r_bad_cnt != 8'hFF) begin
                        r_bad_cnt <= r_bad_cnt + 8'd1;
                     end
                  end
               end
            end
            S_ACK_A, S_ACK_H, S_ACK_L: begin
               if (w_scl_fall) begin
                  r_sda_oe <= 1'b0;
                  r_state  <= (r_state == S_ACK_H) ? S_LO : S_HI;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_if.o_sda_oe = r_sda_oe;
   assign o_wr_valid      = r_wr_valid;
   assign o_wr_addr       = r_wr_addr;
   assign o_wr_data       = r_wr_data;
   assign o_busy          = r_busy;
   assign o_nack_cnt      = r_nack_cnt;
   assign o_bad_cnt       = r_bad_cnt;
   assign o_state         = r_state;
   assign o_rd_data       = ({4'b0, i_rd_addr} < LP_NUM_REGS) ? r_shadow[i_rd_addr] : 9'd0;

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Bench for the WM8731 I2C responder: a bit-banged open-drain master drives
// frames, a frame-level model predicts commits, shadow contents and counters.
module tb_wm8731_i2c_responder;
   import wm8731_pkg::*;

   localparam int Q = 10;  // i_clk cycles per quarter SCL period

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  rd_addr = 4'd0;
   logic        m_sda = 1'b1;
   logic        wr_valid, busy;
   logic [6:0]  wr_addr;
   logic [8:0]  wr_data, rd_data;
   logic [7:0]  nack_cnt, bad_cnt;
   state_t      state;

   int n_checks = 0;
   int n_errors = 0;

   wm8731_i2c_responder_if bus();
   assign bus.i_sda = m_sda & ~bus.o_sda_oe;

   wm8731_i2c_responder dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .bus_if     (bus),
      .o_wr_valid (wr_valid),
      .o_wr_addr  (wr_addr),
      .o_wr_data  (wr_data),
      .o_busy     (busy),
      .o_nack_cnt (nack_cnt),
      .o_bad_cnt  (bad_cnt),
      .i_rd_addr  (rd_addr),
      .o_rd_data  (rd_data),
      .o_state    (state)
   );

   // ---------------- clock / watchdog ----------------
   always #10 clk = ~clk;

   initial begin
      #(1_500_000);
      $display("FAIL watchdog: simulation time limit reached, %0d errors so far", n_errors);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   logic [8:0]  dflt [16];
   logic [8:0]  m_shadow [16];
   int          m_nack, m_bad;
   logic [15:0] exp_q [$];
   logic [7:0]  fq [$];

   function automatic void model_reset();
      m_shadow = dflt;
      m_nack = 0;
      m_bad = 0;
      exp_q.delete();
   endfunction

   function automatic void model_word(input logic [6:0] a, input logic [8:0] d);
      exp_q.push_back({a, d});
      if (a == 7'd15) m_shadow = dflt;
      else if (a < 7'd16) m_shadow[a[3:0]] = d;
      else if (m_bad < 255) m_bad++;
   endfunction

   function automatic void model_nack();
      if (m_nack < 255) m_nack++;
   endfunction

   // ---------------- scoreboard / always-on monitor ----------------
   logic        prev_valid = 1'b0;
   logic        oe_seen = 1'b0;
   logic [15:0] mon_exp;

   always @(negedge clk) begin
      if (wr_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL commit_unexpected: got addr %0d data %h, expected no commit", wr_addr, wr_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({wr_addr, wr_data} !== mon_exp) begin
               n_errors++;
               $display("FAIL commit_value: got addr %0d data %h, expected addr %0d data %h",
                        wr_addr, wr_data, mon_exp[15:9], mon_exp[8:0]);
            end
         end
         n_checks++;
         if (prev_valid) begin
            n_errors++;
            $display("FAIL wr_valid_width: got 2 consecutive cycles, expected 1");
         end
      end
      prev_valid = wr_valid;
      if (bus.o_sda_oe) begin
         oe_seen = 1'b1;
         n_checks++;
         if (!(state inside {S_ACK_A, S_ACK_H, S_ACK_L})) begin
            n_errors++;
            $display("FAIL oe_outside_ack: got state %0d with sda_oe=1, expected an ACK state", state);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; wq(Q);
      bus.i_scl = 1'b1; wq(Q);
      m_sda = 1'b0; wq(Q);
      bus.i_scl = 1'b0; wq(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wq(Q);
      bus.i_scl = 1'b1; wq(Q);
      m_sda = 1'b1; wq(2 * Q);
   endtask

   task automatic i2c_bit(input logic b);
      m_sda = b; wq(Q);
      bus.i_scl = 1'b1; wq(2 * Q);
      bus.i_scl = 1'b0; wq(Q);
   endtask

   task automatic i2c_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
      m_sda = 1'b1; wq(Q);
      bus.i_scl = 1'b1; wq(Q);
      ack = ~bus.i_sda;
      wq(Q);
      bus.i_scl = 1'b0; wq(Q);
   endtask

   task automatic drive_frame(output int acks);
      logic a;
      acks = 0;
      i2c_start();
      foreach (fq[i]) begin
         i2c_byte(fq[i], a);
         if (a) acks++;
      end
      i2c_stop();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_checks++;
      if ({wr_valid, busy, bus.o_sda_oe, wr_addr, wr_data, nack_cnt, bad_cnt} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got valid=%b busy=%b oe=%b addr=%h data=%h nack=%h bad=%h, expected all 0",
                  wr_valid, busy, bus.o_sda_oe, wr_addr, wr_data, nack_cnt, bad_cnt);
      end
      n_checks++;
      if (state !== S_IDLE) begin
         n_errors++;
         $display("FAIL reset_state: got %0d, expected %0d", state, S_IDLE);
      end
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i); #2;
         n_checks++;
         if (rd_data !== dflt[i]) begin
            n_errors++;
            $display("FAIL reset_reg%0d: got %h, expected %h", i, rd_data, dflt[i]);
         end
      end
   endtask

   task automatic test_single_write();
      logic a0, a1, a2;
      i2c_start();
      n_checks++;
      if (busy !== 1'b1) begin
         n_errors++;
         $display("FAIL busy_after_start: got %b, expected 1", busy);
      end
      i2c_byte(8'h34, a0);
      i2c_byte(8'h08, a1);
      model_word(7'd4, 9'h015);
      i2c_byte(8'h15, a2);
      i2c_stop();
      n_checks++;
      if ({a0, a1, a2} !== 3'b111) begin
         n_errors++;
         $display("FAIL single_acks: got %b, expected 111", {a0, a1, a2});
      end
      n_checks++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL single_end: got busy=%b pending=%0d, expected busy=0 pending=0", busy, exp_q.size());
      end
      n_checks++;
      if (wr_addr !== 7'd4 || wr_data !== 9'h015) begin
         n_errors++;
         $display("FAIL single_hold: got addr %0d data %h, expected addr 4 data 015", wr_addr, wr_data);
      end
      rd_addr = 4'd4; #2;
      n_checks++;
      if (rd_data !== 9'h015) begin
         n_errors++;
         $display("FAIL single_rd4: got %h, expected 015", rd_data);
      end
   endtask

   task automatic test_bad_addr();
      int acks;
      oe_seen = 1'b0;
      fq = {8'h36, 8'h08, 8'h15};
      model_nack();
      drive_frame(acks);
      fq = {8'h35, 8'h00};
      model_nack();
      drive_frame(acks);
      n_checks++;
      if (acks != 0 || oe_seen !== 1'b0) begin
         n_errors++;
         $display("FAIL badaddr_ack: got acks=%0d oe_seen=%b, expected 0 and 0", acks, oe_seen);
      end
      n_checks++;
      if (nack_cnt !== 8'(m_nack)) begin
         n_errors++;
         $display("FAIL badaddr_nack_cnt: got %0d, expected %0d", nack_cnt, m_nack);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL badaddr_commits: got %0d missing commits, expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset_reg();
      int acks;
      fq = {8'h34, 8'h00, 8'h17};
      model_word(7'd0, 9'h017);
      drive_frame(acks);
      rd_addr = 4'd0; #2;
      n_checks++;
      if (rd_data !== 9'h017) begin
         n_errors++;
         $display("FAIL resetreg_pre: got %h, expected 017", rd_data);
      end
      fq = {8'h34, 8'h1E, 8'h00};
      model_word(7'd15, 9'h000);
      drive_frame(acks);
      n_checks++;
      if (acks != 3) begin
         n_errors++;
         $display("FAIL resetreg_acks: got %0d, expected 3", acks);
      end
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i); #2;
         n_checks++;
         if (rd_data !== dflt[i]) begin
            n_errors++;
            $display("FAIL resetreg_reg%0d: got %h, expected %h", i, rd_data, dflt[i]);
         end
      end
   endtask

   task automatic test_bad_reg();
      int acks;
      fq = {8'h34, 8'h40, 8'hAB};
      model_word(7'd32, 9'h0AB);
      drive_frame(acks);
      n_checks++;
      if (acks != 3 || bad_cnt !== 8'(m_bad)) begin
         n_errors++;
         $display("FAIL badreg: got acks=%0d bad=%0d, expected acks=3 bad=%0d", acks, bad_cnt, m_bad);
      end
   endtask

   task automatic test_stop_abort();
      int acks;
      fq = {8'h34, 8'h08};
      drive_frame(acks);
      n_checks++;
      if (acks != 2 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL stopabort: got acks=%0d busy=%b, expected acks=2 busy=0", acks, busy);
      end
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i); #2;
         n_checks++;
         if (rd_data !== m_shadow[i]) begin
            n_errors++;
            $display("FAIL stopabort_reg%0d: got %h, expected %h", i, rd_data, m_shadow[i]);
         end
      end
   endtask

   task automatic test_restart_abort();
      int acks;
      logic a0, a1;
      i2c_start();
      i2c_byte(8'h34, a0);
      i2c_byte(8'h08, a1);
      i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b0);
      fq = {8'h34, 8'h0E, 8'h42};
      model_word(7'd7, 9'h042);
      drive_frame(acks);
      n_checks++;
      if (acks != 3 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL restart: got acks=%0d pending=%0d, expected acks=3 pending=0", acks, exp_q.size());
      end
      rd_addr = 4'd7; #2;
      n_checks++;
      if (rd_data !== 9'h042) begin
         n_errors++;
         $display("FAIL restart_rd7: got %h, expected 042", rd_data);
      end
   endtask

   task automatic test_random();
      int acks, exp_acks, nw;
      logic [6:0] a;
      logic [8:0] d;
      for (int f = 0; f < 12; f++) begin
         fq = {};
         if ($urandom_range(0, 5) == 0) begin
            fq.push_back(($urandom_range(0, 1) == 0) ? 8'h36 : 8'h35);
            fq.push_back(8'($urandom_range(0, 255)));
            model_nack();
            exp_acks = 0;
         end else begin
            fq.push_back(8'h34);
            nw = $urandom_range(1, 2);
            for (int w = 0; w < nw; w++) begin
               a = 7'($urandom_range(0, 19));
               d = 9'($urandom_range(0, 511));
               fq.push_back({a, d[8]});
               fq.push_back(d[7:0]);
               model_word(a, d);
            end
            exp_acks = 1 + 2 * nw;
         end
         drive_frame(acks);
         n_checks++;
         if (acks != exp_acks || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL random_frame%0d: got acks=%0d pending=%0d, expected acks=%0d pending=0",
                     f, acks, exp_q.size(), exp_acks);
         end
      end
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i); #2;
         n_checks++;
         if (rd_data !== m_shadow[i]) begin
            n_errors++;
            $display("FAIL random_reg%0d: got %h, expected %h", i, rd_data, m_shadow[i]);
         end
      end
      n_checks++;
      if (nack_cnt !== 8'(m_nack) || bad_cnt !== 8'(m_bad)) begin
         n_errors++;
         $display("FAIL random_counters: got nack=%0d bad=%0d, expected nack=%0d bad=%0d",
                  nack_cnt, bad_cnt, m_nack, m_bad);
      end
   endtask

   task automatic test_reset_midframe();
      int acks;
      logic a;
      fq = {8'h34, 8'h03, 8'hAB};
      model_word(7'd1, 9'h1AB);
      drive_frame(acks);
      i2c_start();
      i2c_byte(8'h34, a);
      for (int i = 7; i >= 0; i--) i2c_bit(i == 1);
      n_checks++;
      if (bus.o_sda_oe !== 1'b1 || state !== S_ACK_H) begin
         n_errors++;
         $display("FAIL midrst_pre: got oe=%b state=%0d, expected oe=1 state=%0d", bus.o_sda_oe, state, S_ACK_H);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      n_checks++;
      if (bus.o_sda_oe !== 1'b0 || state !== S_IDLE || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_post: got oe=%b state=%0d busy=%b, expected 0 %0d 0",
                  bus.o_sda_oe, state, busy, S_IDLE);
      end
      m_sda = 1'b1; wq(Q);
      bus.i_scl = 1'b1; wq(2 * Q);
      bus.i_scl = 1'b0; wq(Q);
      i2c_byte(8'h55, a);
      i2c_stop();
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i); #2;
         n_checks++;
         if (rd_data !== dflt[i]) begin
            n_errors++;
            $display("FAIL midrst_reg%0d: got %h, expected %h", i, rd_data, dflt[i]);
         end
      end
      n_checks++;
      if (nack_cnt !== 8'd0 || bad_cnt !== 8'd0 || state !== S_IDLE) begin
         n_errors++;
         $display("FAIL midrst_tail: got nack=%0d bad=%0d state=%0d, expected 0 0 %0d",
                  nack_cnt, bad_cnt, state, S_IDLE);
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      dflt = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
               9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
      model_reset();
      bus.i_scl = 1'b1;
      m_sda = 1'b1;
      rst = 1'b1;
      wq(5);
      rst = 1'b0;
      wq(5);
      test_reset();
      test_single_write();
      test_bad_addr();
      test_reset_reg();
      test_bad_reg();
      test_stop_abort();
      test_restart_abort();
      test_random();
      test_reset_midframe();
      wq(10);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
